// File: rtl/mon_sopc_ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mon_sopc_ram_arb_pkg
// Shared definitions for the mon_sopc on-chip RAM arbiter slice:
//   - clear-engine FSM state encoding
//   - requester identifiers used by the grant logic and the read-return tag
//   - default geometry of the on-chip RAM (word address, data width, depth)
// -----------------------------------------------------------------------------
package mon_sopc_ram_arb_pkg;

   // Default RAM geometry: 5000 words of 32 bits behind a 13-bit word address.
   localparam int unsigned DEFAULT_ADDR_W = 13;
   localparam int unsigned DEFAULT_DATA_W = 32;
   localparam int unsigned DEFAULT_DEPTH  = 5000;

   // Requester identifiers; also the encoding of last_grant and the read tag.
   localparam logic REQ_M0 = 1'b0;
   localparam logic REQ_M1 = 1'b1;

   // Clear engine: either passing requester traffic or zero-filling the RAM.
   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } clr_state_e;

endpackage : mon_sopc_ram_arb_pkg

// File: rtl/mon_sopc_ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// mon_sopc_ram_arbiter_if
// One Avalon-MM requester port into the RAM arbiter.
//   address       word address                  (requester -> arbiter)
//   byteenable    byte-lane enables             (requester -> arbiter)
//   read / write  request qualifiers            (requester -> arbiter)
//   writedata     write data                    (requester -> arbiter)
//   waitrequest   high = not accepted this clk  (arbiter -> requester)
//   readdata      read data                     (arbiter -> requester)
//   readdatavalid one-cycle read-data strobe    (arbiter -> requester)
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mon_sopc_ram_arbiter_if
   import mon_sopc_ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
   parameter int unsigned DATA_W = DEFAULT_DATA_W
);

   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );

endinterface : mon_sopc_ram_arbiter_if

// File: rtl/mon_sopc_ram_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// mon_sopc_rr_arb2
// Two-way round-robin grant logic. The grant is combinational in the request
// cycle; last_grant remembers the most recent winner so the other requester
// wins the next tie.
//   clk, rst_n  clock / asynchronous active-low reset
//   en          arbitration enable (no grant is issued while low)
//   req[1:0]    request vector, bit K = requester K
//   gnt[1:0]    one-hot grant (or zero)
// -----------------------------------------------------------------------------
module mon_sopc_rr_arb2
   import mon_sopc_ram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_grant;

   always_comb begin
      gnt = '0;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == REQ_M1) ? 2'b01 : 2'b10;
            default: gnt = '0;
         endcase
      end
   end

   // Resets to m1 so that m0 wins the first tie after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= REQ_M1;
      end else if (gnt[0]) begin
         last_grant <= REQ_M0;
      end else if (gnt[1]) begin
         last_grant <= REQ_M1;
      end
   end

endmodule : mon_sopc_rr_arb2

// File: rtl/mon_sopc_ram_arbiter.sv
// -----------------------------------------------------------------------------
// mon_sopc_ram_arbiter
// Shares the single-port mon_sopc on-chip RAM between two Avalon-MM requesters
// with round-robin arbitration and a fixed one-clock read return, and adds a
// clear engine that zero-fills every word while locking both requesters out.
//   clk, reset_n        clock / asynchronous active-low reset
//   m0, m1              requester ports (slave modport of the requester bus)
//   ram_address..ram_clken  RAM-side drive; ram_clken is tied high
//   ram_readdata        RAM read data, valid one clock after the address
//   clr_start           one-cycle pulse requesting a full clear
//   clr_busy            high for exactly DEPTH cycles while clearing
//   clr_done            one-cycle pulse after the final clear write
// -----------------------------------------------------------------------------
module mon_sopc_ram_arbiter
   import mon_sopc_ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned DEPTH  = DEFAULT_DEPTH
)(
   input  logic                clk,
   input  logic                reset_n,

   mon_sopc_ram_arbiter_if.slave m0,
   mon_sopc_ram_arbiter_if.slave m1,

   output logic [ADDR_W-1:0]   ram_address,
   output logic [DATA_W/8-1:0] ram_byteenable,
   output logic                ram_chipselect,
   output logic                ram_write,
   output logic [DATA_W-1:0]   ram_writedata,
   output logic                ram_clken,
   input  logic [DATA_W-1:0]   ram_readdata,

   input  logic                clr_start,
   output logic                clr_busy,
   output logic                clr_done
);

   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

   clr_state_e        state;
   clr_state_e        state_next;
   logic [ADDR_W-1:0] clr_cnt;
   logic              clr_last;

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              arb_en;

   logic              rd_valid;
   logic              rd_id;

   // Write wins over read when a requester illegally asserts both.
   assign req[0] = m0.read | m0.write;
   assign req[1] = m1.read | m1.write;

   // clr_start takes priority over any same-cycle request.
   assign arb_en = reset_n && (state == ST_IDLE) && !clr_start;

   mon_sopc_rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .rst_n (reset_n),
      .en    (arb_en),
      .req   (req),
      .gnt   (gnt)
   );

   assign clr_last = (state == ST_CLEAR) && (clr_cnt == CNT_LAST);

   // State register, clear address counter and clr_done pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         clr_cnt  <= '0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_next;
         clr_done <= clr_last;
         if (state == ST_CLEAR && !clr_last) begin
            clr_cnt <= clr_cnt + 1'b1;
         end else begin
            clr_cnt <= '0;
         end
      end
   end

   // Next-state logic; clr_start is ignored once clearing.
   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE:  if (clr_start) state_next = ST_CLEAR;
         ST_CLEAR: if (clr_last)  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Outputs: RAM drive mux, waitrequests and status.
   always_comb begin
      ram_address    = '0;
      ram_byteenable = '0;
      ram_chipselect = 1'b0;
      ram_write      = 1'b0;
      ram_writedata  = '0;
      ram_clken      = 1'b1;
      clr_busy       = (state == ST_CLEAR);
      m0.waitrequest = 1'b0;
      m1.waitrequest = 1'b0;

      if (state == ST_CLEAR) begin
         ram_address    = clr_cnt;
         ram_byteenable = '1;
         ram_chipselect = 1'b1;
         ram_write      = 1'b1;
         ram_writedata  = '0;
      end else if (gnt[0]) begin
         ram_address    = m0.address;
         ram_byteenable = m0.byteenable;
         ram_chipselect = 1'b1;
         ram_write      = m0.write;
         ram_writedata  = m0.writedata;
      end else if (gnt[1]) begin
         ram_address    = m1.address;
         ram_byteenable = m1.byteenable;
         ram_chipselect = 1'b1;
         ram_write      = m1.write;
         ram_writedata  = m1.writedata;
      end

      if (!reset_n || state == ST_CLEAR || clr_start) begin
         m0.waitrequest = 1'b1;
         m1.waitrequest = 1'b1;
      end else if (gnt != 2'b00) begin
         m0.waitrequest = !gnt[0];
         m1.waitrequest = !gnt[1];
      end

      m0.readdata      = ram_readdata;
      m1.readdata      = ram_readdata;
      m0.readdatavalid = rd_valid && (rd_id == REQ_M0);
      m1.readdatavalid = rd_valid && (rd_id == REQ_M1);
   end

   // Read-return tag: the RAM answers one clock after the address, so the
   // tag only needs to live for a single cycle and steers the strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid <= 1'b0;
         rd_id    <= REQ_M0;
      end else begin
         rd_valid <= (gnt[0] && m0.read && !m0.write) ||
                     (gnt[1] && m1.read && !m1.write);
         rd_id    <= gnt[1] ? REQ_M1 : REQ_M0;
      end
   end

endmodule : mon_sopc_ram_arbiter

// File: doc/mon_sopc_ram_arbiter.md
Name: mon_sopc_ram_arbiter

Overview:
- Two-requester arbiter and clear engine in front of the single-port on-chip RAM in mon_sopc (13-bit word address, 32-bit data, 4 byte lanes, 5000 words).
- Shares the RAM between two Avalon-MM requesters (m0, m1) with round-robin arbitration and fixed-latency read return.
- Adds a sequenced clear function that zero-fills the whole RAM on request and locks out both requesters while it runs.

Parameters:
- ADDR_W, 13, RAM word-address width
- DATA_W, 32, data width; byte lanes = DATA_W/8
- DEPTH, 5000, number of RAM words; clear covers 0..DEPTH-1

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- mK_address  in  ADDR_W  requester K word address (K = 0, 1; each mK_ port below exists per requester)
- mK_byteenable  in  DATA_W/8  requester K byte enables
- mK_read  in  1  read request
- mK_write  in  1  write request
- mK_writedata  in  DATA_W  write data
- mK_waitrequest  out  1  high = request not accepted this cycle
- mK_readdata  out  DATA_W  read data
- mK_readdatavalid  out  1  one-cycle read-data strobe
- ram_address  out  ADDR_W  to RAM address
- ram_byteenable  out  DATA_W/8  to RAM byteenable
- ram_chipselect  out  1  to RAM chipselect
- ram_write  out  1  to RAM write
- ram_writedata  out  DATA_W  to RAM writedata
- ram_clken  out  1  to RAM clken; tied 1
- ram_readdata  in  DATA_W  from RAM; valid one clk after the address is issued
- clr_start  in  1  one-cycle pulse; requests a full clear
- clr_busy  out  1  high while clearing
- clr_done  out  1  one-cycle pulse after the last clear write

Behaviour:
- Reset: reset_n low asynchronously forces the following.
  - FSM = IDLE, clr_busy = 0, clr_done = 0, clear counter = 0.
  - m0/m1_readdatavalid = 0; read-pending tag cleared.
  - last_grant = m1, so m0 wins the first tie.
  - mK_waitrequest = 1 while reset_n is low.
- Request: mK_req = mK_read | mK_write. Read and write both high in the same cycle is illegal; it is treated as a write.
- IDLE arbitration is combinational, same cycle:
  - Only one requester active: it is granted.
  - Both active: the requester not equal to last_grant is granted.
  - last_grant updates on every grant.
  - Granted requester: waitrequest = 0. Other requester: waitrequest = 1 and must hold its request stable.
  - No request: waitrequest = 0 for both; ram_chipselect = 0.
- RAM drive: ram_address, ram_byteenable, ram_writedata and ram_write = granted mK_write come from the granted requester; ram_chipselect = 1 on a grant.
- Read return:
  - A granted read registers a tag (valid plus requester id).
  - Next cycle, that requester's readdatavalid = 1 and mK_readdata = ram_readdata.
  - Latency is exactly 1 clk. Back-to-back reads, including alternating requesters, sustain 1 per cycle.
  - mK_readdata is don't-care when readdatavalid = 0.
- Writes complete in the grant cycle; there is no response.
- CLEAR FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR: on clr_start = 1. clr_start wins over any same-cycle requester; both waitrequest = 1 in that cycle.
  - In CLEAR, each cycle drives ram_chipselect = 1, ram_write = 1, ram_byteenable = all ones, ram_writedata = 0, ram_address = counter, then increments the counter.
  - Both waitrequest = 1 and clr_busy = 1 throughout CLEAR.
  - After the write to address DEPTH-1: counter -> 0, FSM -> IDLE, clr_done = 1 for one clk, clr_busy = 0.
  - Duration: exactly DEPTH cycles of clr_busy.
  - clr_start while in CLEAR is ignored.
  - A read granted the cycle before CLEAR entry still returns its readdatavalid in the first CLEAR cycle.
- Reset mid-clear aborts immediately. RAM contents are then partially cleared; this is acceptable.
- Counter width is ADDR_W and never exceeds DEPTH-1.

Decomposition:
- Package mon_sopc_ram_arb_pkg holds:
  - FSM state enum (ST_IDLE, ST_CLEAR)
  - requester-id constants (REQ_M0 = 0, REQ_M1 = 1)
  - defaults ADDR_W / DATA_W / DEPTH
- One sub-module: mon_sopc_rr_arb2, the two-way round-robin grant logic with last_grant register.
- Datapath muxing, read tag and clear FSM stay in the top.

Test Plan:
- Reset release, m0 writes 0xDEADBEEF to addr 5 (be = 0xF), then reads addr 5 -> m0_waitrequest = 0 both cycles; m0_readdatavalid = 1 exactly one clk after the read grant with readdata 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both read continuously (addr 1 and addr 2, preloaded 0x11 / 0x22) -> grants alternate m0, m1, m0, ... (m0 first); each readdatavalid returns the correct value 1 clk after its grant; no lost or duplicated strobes.
- Byte-enable write: m1 writes 0xAABBCCDD to addr 7 with be = 0x4 over 0x00000000, then reads -> 0x00BB0000.
- clr_start pulse after filling addrs 0..4999 with 0xFFFFFFFF -> clr_busy high exactly 5000 clks, waitrequest high for both; clr_done single pulse; reads of addrs 0, 2500 and 4999 afterwards return 0.
- clr_start in the same cycle as an m0 write to addr 3 -> m0 stalled (waitrequest = 1) until clr_done, then its write completes; addr 3 then reads back the written value.
- reset_n asserted at clear cycle 100 -> clr_busy = 0 immediately, no clr_done pulse; after release, addr 99 reads 0 and addr 200 still holds its old value.
